// File: rtl/conv_window_feeder_pkg.sv
// conv_window_feeder_pkg: shared types and constants for the conv feeder.
// FSM encoding, kernel geometry, engine latency and tap offset helper.
package conv_window_feeder_pkg;

  localparam int KERNAL_SIZE = 5;
  localparam int PIPE_LATENCY = 6;
  localparam int NUM_TAPS = KERNAL_SIZE * KERNAL_SIZE;
  localparam logic [31:0] FP_ONE = 32'h3F800000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_W,
    ST_FILL,
    ST_RUN,
    ST_DRAIN
  } state_t;

  // Line buffer slot feeding tap n (0-based, row-major, row 0 on top).
  // buf[0] is the newest pixel, i.e. the bottom-right corner.
  function automatic int tap_offset(input int n, input int ifm_size);
    int r;
    int c;
    r = n / KERNAL_SIZE;
    c = n % KERNAL_SIZE;
    return (KERNAL_SIZE - 1 - r) * ifm_size + (KERNAL_SIZE - 1 - c);
  endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// conv_line_buffer: FIFO_SIZE-deep pixel shift register, 25 window taps.
// Ports: clk, reset (async low), shift_en, din, taps (tap1 in low word).
module conv_line_buffer
  import conv_window_feeder_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int IFM_SIZE   = 14,
  localparam int FIFO_SIZE =
    (KERNAL_SIZE - 1) * IFM_SIZE + KERNAL_SIZE
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           shift_en,
  input  logic [DATA_WIDTH-1:0]          din,
  output logic [NUM_TAPS*DATA_WIDTH-1:0] taps
);

  logic [DATA_WIDTH-1:0] buf_q [FIFO_SIZE];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < FIFO_SIZE; i++)
        buf_q[i] <= '0;
    end else if (shift_en) begin
      buf_q[0] <= din;
      for (int i = 1; i < FIFO_SIZE; i++)
        buf_q[i] <= buf_q[i-1];
    end
  end

  for (genvar n = 0; n < NUM_TAPS; n++) begin : g_tap
    localparam int OFF = tap_offset(n, IFM_SIZE);
    assign taps[n*DATA_WIDTH +: DATA_WIDTH] = buf_q[OFF];
  end

endmodule

// File: rtl/conv_window_feeder.sv
// conv_window_feeder: builds 5x5 windows and weights for a 25-tap FP engine.
// Ports: start/w_*/px_* in, w_taps/if_taps/conv_enable out, res_* tracked out.
module conv_window_feeder #(
  parameter int DATA_WIDTH = 32,
  parameter int IFM_SIZE   = 14,
  parameter int KERNAL_SIZE =
    conv_window_feeder_pkg::KERNAL_SIZE,
  parameter int PIPE_LATENCY =
    conv_window_feeder_pkg::PIPE_LATENCY,
  localparam int IFM_SIZE_NEXT = IFM_SIZE - KERNAL_SIZE + 1,
  localparam int FIFO_SIZE =
    (KERNAL_SIZE - 1) * IFM_SIZE + KERNAL_SIZE,
  localparam int ADDRESS_SIZE_NEXT_IFM =
    $clog2(IFM_SIZE_NEXT * IFM_SIZE_NEXT),
  localparam int NT = KERNAL_SIZE * KERNAL_SIZE
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start,
  input  logic                             w_valid,
  input  logic [DATA_WIDTH-1:0]            w_data,
  input  logic                             px_valid,
  output logic                             px_ready,
  input  logic [DATA_WIDTH-1:0]            px_data,
  output logic [NT*DATA_WIDTH-1:0]         w_taps,
  output logic [NT*DATA_WIDTH-1:0]         if_taps,
  output logic                             conv_enable,
  input  logic [DATA_WIDTH-1:0]            conv_data_in,
  output logic                             res_valid,
  output logic [DATA_WIDTH-1:0]            res_data,
  output logic [ADDRESS_SIZE_NEXT_IFM-1:0] res_addr,
  output logic                             busy,
  output logic                             frame_done
);
  import conv_window_feeder_pkg::*;

  localparam int CW = $clog2(IFM_SIZE);
  localparam int AW = ADDRESS_SIZE_NEXT_IFM;
  localparam int LAST_ADDR = IFM_SIZE_NEXT * IFM_SIZE_NEXT - 1;

  state_t state_q;
  state_t state_d;

  logic [DATA_WIDTH-1:0]   w_bank [NT];
  logic [4:0]              w_cnt;
  logic [CW-1:0]           col;
  logic [CW-1:0]           row;
  logic [PIPE_LATENCY-1:0] pipe_q;
  logic                    px_hs;
  logic                    col_last;
  logic                    row_last;
  logic                    win_hs;
  logic                    frame_start;
  logic                    w_load;
  logic                    last_res;

  assign px_hs       = px_valid & px_ready;
  assign col_last    = (col == CW'(IFM_SIZE - 1));
  assign row_last    = (row == CW'(IFM_SIZE - 1));
  assign frame_start = (state_q == ST_IDLE) & start;
  assign w_load      = (state_q == ST_LOAD_W) & w_valid;
  assign last_res    = res_valid & (res_addr == AW'(LAST_ADDR));

  // Window is complete once the newest pixel has 4 rows/cols behind it.
  assign win_hs = px_hs
    & (row >= CW'(KERNAL_SIZE - 1))
    & (col >= CW'(KERNAL_SIZE - 1));

  always_comb begin
    state_d  = state_q;
    px_ready = 1'b0;
    busy     = 1'b1;
    unique case (state_q)
      ST_IDLE: begin
        busy = 1'b0;
        if (start)
          state_d = ST_LOAD_W;
      end
      ST_LOAD_W: begin
        if (w_valid && w_cnt == 5'(NT - 1))
          state_d = ST_FILL;
      end
      ST_FILL: begin
        px_ready = 1'b1;
        if (px_hs && col_last
            && row == CW'(KERNAL_SIZE - 2))
          state_d = ST_RUN;
      end
      ST_RUN: begin
        px_ready = 1'b1;
        if (px_hs && col_last && row_last)
          state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (last_res)
          state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      state_q <= ST_IDLE;
    else
      state_q <= state_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      w_cnt <= '0;
      for (int i = 0; i < NT; i++)
        w_bank[i] <= '0;
    end else if (frame_start) begin
      w_cnt <= '0;
    end else if (w_load) begin
      w_bank[w_cnt] <= w_data;
      w_cnt <= w_cnt + 5'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      col <= '0;
      row <= '0;
    end else if (frame_start) begin
      col <= '0;
      row <= '0;
    end else if (px_hs) begin
      if (col_last) begin
        col <= '0;
        row <= row + CW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end

  // conv_enable rides this delay line to line up with the engine output.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      conv_enable <= 1'b0;
      pipe_q      <= '0;
      res_valid   <= 1'b0;
      res_data    <= '0;
      frame_done  <= 1'b0;
    end else begin
      conv_enable <= win_hs;
      pipe_q      <= {pipe_q[PIPE_LATENCY-2:0], conv_enable};
      res_valid   <= pipe_q[PIPE_LATENCY-1];
      res_data    <= conv_data_in;
      frame_done  <= (state_q == ST_DRAIN) & last_res;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      res_addr <= '0;
    else if (frame_start)
      res_addr <= '0;
    else if (res_valid)
      res_addr <= res_addr + AW'(1);
  end

  for (genvar n = 0; n < NT; n++) begin : g_w
    assign w_taps[n*DATA_WIDTH +: DATA_WIDTH] = w_bank[n];
  end

  conv_line_buffer #(
    .DATA_WIDTH (DATA_WIDTH),
    .IFM_SIZE   (IFM_SIZE)
  ) u_line_buffer (
    .clk      (clk),
    .reset    (reset),
    .shift_en (px_hs),
    .din      (px_data),
    .taps     (if_taps)
  );

endmodule

// File: tb/tb_conv_window_feeder.sv
// tb_conv_window_feeder: scoreboard bench with an integer-valued engine model.
// Stimulus pushes expected taps/results; a negedge monitor pops and compares.
module tb_conv_window_feeder;
  import conv_window_feeder_pkg::*;

  localparam int DW   = 32;
  localparam int IFM  = 14;
  localparam int NXT  = 10;
  localparam int NT   = 25;
  localparam int AW   = 7;
  localparam int NPIX = IFM * IFM;
  localparam int VW   = NT * DW;

  logic           clk;
  logic           reset;
  logic           start;
  logic           w_valid;
  logic [DW-1:0]  w_data;
  logic           px_valid;
  logic           px_ready;
  logic [DW-1:0]  px_data;
  logic [VW-1:0]  w_taps;
  logic [VW-1:0]  if_taps;
  logic           conv_enable;
  logic [DW-1:0]  conv_data_in;
  logic           res_valid;
  logic [DW-1:0]  res_data;
  logic [AW-1:0]  res_addr;
  logic           busy;
  logic           frame_done;

  conv_window_feeder dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .w_valid      (w_valid),
    .w_data       (w_data),
    .px_valid     (px_valid),
    .px_ready     (px_ready),
    .px_data      (px_data),
    .w_taps       (w_taps),
    .if_taps      (if_taps),
    .conv_enable  (conv_enable),
    .conv_data_in (conv_data_in),
    .res_valid    (res_valid),
    .res_data     (res_data),
    .res_addr     (res_addr),
    .busy         (busy),
    .frame_done   (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    logic [AW-1:0] addr;
  } res_t;

  res_t          exp_res [$];
  logic [VW-1:0] exp_if  [$];
  logic [VW-1:0] exp_w   [$];
  int            en_cyc  [$];

  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   c0       = 0;
  logic hs_last  = 1'b0;
  bit   cur_wr   = 1'b0;

  task automatic check(input string name,
                       input logic [VW-1:0] act,
                       input logic [VW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=none expected=event", name);
  endtask

  function automatic logic [31:0] fp_of_int(input int v);
    int m;
    logic [31:0] t;
    if (v <= 0) return 32'h0;
    m = 0;
    for (int i = 0; i < 24; i++)
      if (v[i]) m = i;
    t = 32'(v) << (23 - m);
    return {1'b0, 8'(127 + m), t[22:0]};
  endfunction

  function automatic int int_of_fp(input logic [31:0] f);
    int e;
    logic [31:0] m;
    e = int'(f[30:23]);
    m = {8'd0, 1'b1, f[22:0]};
    if (e == 0) return 0;
    if (e >= 150) return int'(m << (e - 150));
    return int'(m >> (150 - e));
  endfunction

  function automatic int px_val(input int idx, input bit pr);
    return pr ? idx : 1;
  endfunction

  function automatic logic [VW-1:0] w_vec(input bit wr);
    logic [VW-1:0] v;
    v = '0;
    for (int n = 0; n < NT; n++)
      v[n*DW +: DW] = wr ? fp_of_int(n + 1) : FP_ONE;
    return v;
  endfunction

  function automatic logic [VW-1:0] if_vec(input int i, input int j,
                                           input bit pr);
    logic [VW-1:0] v;
    int idx;
    v = '0;
    for (int n = 0; n < NT; n++) begin
      idx = (i + n / 5) * IFM + j + n % 5;
      v[n*DW +: DW] = pr ? fp_of_int(idx) : FP_ONE;
    end
    return v;
  endfunction

  function automatic int win_sum(input int i, input int j,
                                 input bit wr, input bit pr);
    int s;
    s = 0;
    for (int n = 0; n < NT; n++)
      s += (wr ? n + 1 : 1)
         * px_val((i + n / 5) * IFM + j + n % 5, pr);
    return s;
  endfunction

  // Engine model: free-running 6-stage delay of the tap dot product.
  logic [DW-1:0] eng_q [6];
  assign conv_data_in = eng_q[5];

  always @(posedge clk) begin
    int s;
    s = 0;
    for (int n = 0; n < NT; n++)
      s = s + int_of_fp(w_taps[n*DW +: DW])
            * int_of_fp(if_taps[n*DW +: DW]);
    eng_q[0] <= fp_of_int(s);
    for (int k = 1; k < 6; k++)
      eng_q[k] <= eng_q[k-1];
  end

  always @(posedge clk) begin
    cyc     <= cyc + 1;
    hs_last <= px_valid & px_ready;
  end

  always @(negedge clk) begin
    if (conv_enable) begin
      check("en_after_hs", VW'(hs_last), VW'(1));
      en_cyc.push_back(cyc);
      if (exp_if.size() == 0) begin
        fail_now("taps_unexpected");
      end else begin
        check("if_taps", if_taps, exp_if.pop_front());
        check("w_taps", w_taps, exp_w.pop_front());
      end
    end
    if (res_valid) begin
      if (exp_res.size() == 0) begin
        fail_now("res_unexpected");
      end else begin
        res_t e;
        e = exp_res.pop_front();
        check("res_data", VW'(res_data), VW'(e.data));
        check("res_addr", VW'(res_addr), VW'(e.addr));
      end
      if (en_cyc.size() != 0)
        check("latency", VW'(cyc - en_cyc.pop_front()), VW'(7));
    end
  end

  task automatic chk_idle(input string tag);
    check({tag, "_px_ready"}, VW'(px_ready), '0);
    check({tag, "_conv_en"}, VW'(conv_enable), '0);
    check({tag, "_res_valid"}, VW'(res_valid), '0);
    check({tag, "_busy"}, VW'(busy), '0);
    check({tag, "_frame_done"}, VW'(frame_done), '0);
    check({tag, "_res_addr"}, VW'(res_addr), '0);
    check({tag, "_res_data"}, VW'(res_data), '0);
    check({tag, "_if_taps"}, if_taps, '0);
    check({tag, "_w_taps"}, w_taps, '0);
  endtask

  task automatic load_weights(input bit wr);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int n = 0; n < NT; n++) begin
      if (n == 12) begin
        w_valid = 1'b0;
        @(posedge clk); #1;
      end
      w_valid = 1'b1;
      w_data  = wr ? fp_of_int(n + 1) : FP_ONE;
      @(posedge clk); #1;
    end
    w_valid = 1'b0;
    cur_wr  = wr;
  endtask

  task automatic run_pixels(input bit pr, input bit gaps,
                            input int abort_at, input bit poke);
    int t;
    int g;
    int row;
    int col;
    res_t e;
    for (int k = 0; k < NPIX; k++) begin
      if (k == abort_at) begin
        px_valid = 1'b0;
        return;
      end
      g = 0;
      while (gaps && $urandom_range(0, 1) == 1 && g < 3) begin
        px_valid = 1'b0;
        @(posedge clk); #1;
        g++;
      end
      if (poke && k == 120) begin
        start   = 1'b1;
        w_valid = 1'b1;
        w_data  = 32'hDEADBEEF;
      end
      px_valid = 1'b1;
      px_data  = pr ? fp_of_int(k) : FP_ONE;
      t = 0;
      while (!px_ready && t < 50) begin
        @(posedge clk); #1;
        t++;
      end
      if (!px_ready) begin
        fail_now("px_ready_timeout");
        px_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
      start   = 1'b0;
      w_valid = 1'b0;
      if (k == 0) c0 = cyc;
      row = k / IFM;
      col = k % IFM;
      if (row >= 4 && col >= 4) begin
        e.addr = AW'((row - 4) * NXT + col - 4);
        if (!pr && !cur_wr)
          e.data = 32'h41C80000;
        else
          e.data = fp_of_int(win_sum(row - 4, col - 4, cur_wr, pr));
        exp_res.push_back(e);
        exp_if.push_back(if_vec(row - 4, col - 4, pr));
        exp_w.push_back(w_vec(cur_wr));
      end
    end
    px_valid = 1'b0;
  endtask

  task automatic wait_done(input bit chk_len);
    int t;
    t = 0;
    @(negedge clk);
    while (!frame_done && t < 400) begin
      @(negedge clk);
      t++;
    end
    if (!frame_done) begin
      fail_now("frame_done_timeout");
      return;
    end
    check("busy_at_done", VW'(busy), '0);
    check("res_left", VW'(exp_res.size()), '0);
    if (chk_len)
      check("frame_len", VW'(cyc - c0), VW'(NPIX + 7));
  endtask

  initial begin
    reset    = 1'b0;
    start    = 1'b0;
    w_valid  = 1'b0;
    w_data   = '0;
    px_valid = 1'b0;
    px_data  = '0;
    repeat (2) @(negedge clk);
    chk_idle("rst");
    @(posedge clk); #1 reset = 1'b1;

    load_weights(1'b0);
    run_pixels(1'b0, 1'b0, -1, 1'b0);
    wait_done(1'b1);

    load_weights(1'b1);
    run_pixels(1'b1, 1'b0, -1, 1'b0);
    wait_done(1'b1);

    load_weights(1'b1);
    run_pixels(1'b1, 1'b1, -1, 1'b1);
    wait_done(1'b0);

    load_weights(1'b0);
    run_pixels(1'b1, 1'b0, 100, 1'b0);
    @(posedge clk); #1 reset = 1'b0;
    exp_res.delete();
    exp_if.delete();
    exp_w.delete();
    en_cyc.delete();
    repeat (3) begin
      @(negedge clk);
      chk_idle("midrst");
    end
    @(posedge clk); #1 reset = 1'b1;
    repeat (10) begin
      @(negedge clk);
      check("post_rst_res_valid", VW'(res_valid), '0);
    end

    load_weights(1'b1);
    run_pixels(1'b1, 1'b0, -1, 1'b0);
    wait_done(1'b1);

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
